zmod_pll_sequencer: RTL and testbench

Parametrised reset/lock sequencer for the Zmod converter clocking PLL. Holds the PLL in reset for a fixed time, then waits for lock with timeout and retry, requires lock to stay stable, and releases NUM_CH downstream channel resets in a staggered order. It monitors lock continuously, records lock losses and retries, and re-runs the full sequence on lock loss or on request. The block runs on the free-running PLL reference clock, upstream of every block clocked by PLL outputs.

---
 rtl/zmod_pll_sequencer.sv | 166 ++++++++++++++++
 tb/tb_zmod_pll_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zmod_pll_sequencer.sv
// Reset/lock sequencer for the Zmod converter PLL: holds PLL reset, waits for a
// stable lock with timeout/retry, then releases channel resets in index order.
module zmod_pll_sequencer #(
  parameter int NUM_CH        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int RST_HOLD      = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGGER       = 8,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              restart,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              ready,
  output logic [CNT_W-1:0]  retry_count,
  output logic [CNT_W-1:0]  lost_count,
  output logic              timeout
);

  localparam int REL_CYCLES = STAGGER * NUM_CH;
  localparam int MAX_A      = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
  localparam int MAX_B      = (STABLE_CYCLES > REL_CYCLES) ? STABLE_CYCLES : REL_CYCLES;
  localparam int MAX_C      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W      = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0]      ch_rst_q, ch_rst_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       retry_q, retry_d;
  logic [CNT_W-1:0]       lost_q, lost_d;
  logic                   timeout_q, timeout_d;
  logic                   go_reset;
  logic                   lk;
  logic [NUM_CH-1:0]      rel_due;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign lk     = sync_q[SYNC_STAGES-1];

  // Channel i is due for release once the release timer reaches STAGGER*i.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rel
      assign rel_due[gi] = (int'(timer_d) >= STAGGER * gi);
    end
  endgenerate

  // One shared timer serves every state since only one interval runs at a time.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TMR_W'(1);
    retry_d   = retry_q;
    lost_d    = lost_q;
    timeout_d = timeout_q;
    go_reset  = 1'b0;

    case (state_q)
      RESET_PLL: begin
        if (timer_q == TMR_W'(RST_HOLD - 1)) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
          timeout_d = 1'b1;
          go_reset  = 1'b1;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
          state_d = RELEASE;
          timer_d = '0;
        end
      end
      RELEASE: begin
        if (!lk) begin
          if (lost_q != '1) lost_d = lost_q + CNT_W'(1);
          go_reset = 1'b1;
        end else if (timer_d == TMR_W'(REL_CYCLES)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        timer_d = timer_q;
        if (!lk) begin
          if (lost_q != '1) lost_d = lost_q + CNT_W'(1);
          go_reset = 1'b1;
        end
      end
      default: go_reset = 1'b1;
    endcase

    if (restart) go_reset = 1'b1;

    if (go_reset) begin
      state_d = RESET_PLL;
      timer_d = '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    pll_rst_d = (state_d == RESET_PLL);
    ready_d   = (state_d == RUN);
    if (state_d == RUN) timeout_d = 1'b0;

    if (state_d == RESET_PLL)
      ch_rst_d = '1;
    else if (state_d == RELEASE || state_d == RUN)
      ch_rst_d = ch_rst_q & ~rel_due;
    else
      ch_rst_d = ch_rst_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      timer_q   <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      ch_rst_q  <= '1;
      ready_q   <= 1'b0;
      retry_q   <= '0;
      lost_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      ch_rst_q  <= ch_rst_d;
      ready_q   <= ready_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      timeout_q <= timeout_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign ch_rst      = ch_rst_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_zmod_pll_sequencer.sv
// Bench for zmod_pll_sequencer: timed expectations are queued as stimulus is
// applied and checked when the simulation reaches their due cycle.
module tb_zmod_pll_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic [2:0] ch_rst;
  logic       ready;
  logic [7:0] retry_count;
  logic [7:0] lost_count;
  logic       timeout;
  logic       pll_rst2;
  logic [2:0] ch_rst2;
  logic       ready2;
  logic [1:0] retry2;
  logic [1:0] lost2;
  logic       timeout2;

  zmod_pll_sequencer #(
    .NUM_CH(3), .SYNC_STAGES(2), .RST_HOLD(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .STAGGER(2), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .ch_rst(ch_rst), .ready(ready),
    .retry_count(retry_count), .lost_count(lost_count), .timeout(timeout)
  );

  // Narrow counters to exercise saturation; lock never arrives.
  zmod_pll_sequencer #(
    .NUM_CH(3), .SYNC_STAGES(2), .RST_HOLD(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .STAGGER(2), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst2), .pll_locked(1'b0), .restart(1'b0),
    .pll_rst(pll_rst2), .ch_rst(ch_rst2), .ready(ready2),
    .retry_count(retry2), .lost_count(lost2), .timeout(timeout2)
  );

  always #5 clk = ~clk;

  localparam int S_PLL = 0, S_CH = 1, S_RDY = 2, S_RETRY = 3, S_LOST = 4, S_TMO = 5, S_RETRY2 = 6;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       pr;
    logic [2:0] ch;
    logic       rdy;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic logic [7:0] act(int sel);
    case (sel)
      S_PLL:    return {7'b0, pll_rst};
      S_CH:     return {5'b0, ch_rst};
      S_RDY:    return {7'b0, ready};
      S_RETRY:  return retry_count;
      S_LOST:   return lost_count;
      S_TMO:    return {7'b0, timeout};
      S_RETRY2: return {6'b0, retry2};
      default:  return 8'h00;
    endcase
  endfunction

  function automatic string sname(int sel);
    case (sel)
      S_PLL:    return "pll_rst";
      S_CH:     return "ch_rst";
      S_RDY:    return "ready";
      S_RETRY:  return "retry";
      S_LOST:   return "lost";
      S_TMO:    return "timeout";
      S_RETRY2: return "retry_sat";
      default:  return "unknown";
    endcase
  endfunction

  task automatic check(string name, logic [7:0] a, logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("chk %-9s cyc %0d got %0h exp %0h FAIL", name, cyc, a, e);
    end else begin
      $display("chk %-9s cyc %0d got %0h exp %0h ok", name, cyc, a, e);
    end
  endtask

  task automatic expect_at(int due, int sel, logic [7:0] v);
    sb.push_back('{due: due, sel: sel, val: v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sname(sb[i].sel), act(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  // Any expectation left over was never reached: count it as a failure.
  task automatic finish_phase();
    for (int i = 0; i < sb.size(); i++) begin
      checks++;
      errors++;
      $display("chk %-9s due %0d never checked FAIL", sname(sb[i].sel), sb[i].due);
    end
    sb.delete();
  endtask

  task automatic do_reset(logic lock);
    rst        = 1'b1;
    restart    = 1'b0;
    pll_locked = lock;
    @(posedge clk);
    #1;
    check("rst_pll", {7'b0, pll_rst}, 8'h01);
    check("rst_ch", {5'b0, ch_rst}, 8'h07);
    check("rst_rdy", {7'b0, ready}, 8'h00);
    check("rst_cnt", retry_count | lost_count, 8'h00);
    check("rst_tmo", {7'b0, timeout}, 8'h00);
    rst = 1'b0;
    cyc = 0;
  endtask

  vec_t tbl[10];

  initial begin
    // Clean bring-up with lock raised at cycle 10.
    tbl[0] = '{cyc: 1,  pr: 1'b1, ch: 3'b111, rdy: 1'b0};
    tbl[1] = '{cyc: 3,  pr: 1'b1, ch: 3'b111, rdy: 1'b0};
    tbl[2] = '{cyc: 4,  pr: 1'b0, ch: 3'b111, rdy: 1'b0};
    tbl[3] = '{cyc: 20, pr: 1'b0, ch: 3'b111, rdy: 1'b0};
    tbl[4] = '{cyc: 21, pr: 1'b0, ch: 3'b110, rdy: 1'b0};
    tbl[5] = '{cyc: 22, pr: 1'b0, ch: 3'b110, rdy: 1'b0};
    tbl[6] = '{cyc: 23, pr: 1'b0, ch: 3'b100, rdy: 1'b0};
    tbl[7] = '{cyc: 25, pr: 1'b0, ch: 3'b000, rdy: 1'b0};
    tbl[8] = '{cyc: 26, pr: 1'b0, ch: 3'b000, rdy: 1'b0};
    tbl[9] = '{cyc: 27, pr: 1'b0, ch: 3'b000, rdy: 1'b1};

    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      expect_at(tbl[i].cyc, S_PLL, {7'b0, tbl[i].pr});
      expect_at(tbl[i].cyc, S_CH, {5'b0, tbl[i].ch});
      expect_at(tbl[i].cyc, S_RDY, {7'b0, tbl[i].rdy});
    end
    expect_at(27, S_RETRY, 8'd0);
    expect_at(27, S_LOST, 8'd0);
    expect_at(27, S_TMO, 8'd0);
    run_to(10);
    pll_locked = 1'b1;
    run_to(28);

    // Lock loss in RUN at cycle 30, relock three cycles later.
    run_to(30);
    pll_locked = 1'b0;
    expect_at(32, S_RDY, 8'd1);
    expect_at(32, S_CH, 8'd0);
    expect_at(33, S_RDY, 8'd0);
    expect_at(33, S_CH, 8'd7);
    expect_at(33, S_PLL, 8'd1);
    expect_at(33, S_LOST, 8'd1);
    run_to(33);
    pll_locked = 1'b1;
    expect_at(45, S_CH, 8'd7);
    expect_at(46, S_CH, 8'd6);
    expect_at(51, S_RDY, 8'd0);
    expect_at(52, S_RDY, 8'd1);
    expect_at(52, S_LOST, 8'd1);
    run_to(53);
    finish_phase();

    // Timeout/retry: three timeouts, then lock.
    do_reset(1'b0);
    expect_at(35, S_PLL, 8'd0);
    expect_at(35, S_RETRY, 8'd0);
    expect_at(36, S_PLL, 8'd1);
    expect_at(36, S_RETRY, 8'd1);
    expect_at(36, S_TMO, 8'd1);
    expect_at(39, S_PLL, 8'd1);
    expect_at(40, S_PLL, 8'd0);
    expect_at(72, S_RETRY, 8'd2);
    expect_at(108, S_RETRY, 8'd3);
    expect_at(126, S_TMO, 8'd1);
    expect_at(126, S_RDY, 8'd0);
    expect_at(127, S_RDY, 8'd1);
    expect_at(127, S_TMO, 8'd0);
    expect_at(127, S_RETRY, 8'd3);
    run_to(110);
    pll_locked = 1'b1;
    run_to(128);
    finish_phase();

    // Unstable lock: 5 good STABLE cycles, 2-cycle dropout, full recount.
    do_reset(1'b1);
    expect_at(13, S_CH, 8'd7);
    expect_at(20, S_CH, 8'd7);
    expect_at(21, S_CH, 8'd6);
    expect_at(21, S_LOST, 8'd0);
    run_to(8);
    pll_locked = 1'b0;
    run_to(10);
    pll_locked = 1'b1;
    run_to(22);

    // Restart mid-RELEASE after channel 0 has dropped.
    expect_at(23, S_CH, 8'd7);
    expect_at(23, S_PLL, 8'd1);
    expect_at(23, S_RDY, 8'd0);
    expect_at(26, S_PLL, 8'd1);
    expect_at(27, S_PLL, 8'd0);
    expect_at(27, S_RETRY, 8'd0);
    expect_at(27, S_LOST, 8'd0);
    expect_at(41, S_RDY, 8'd0);
    expect_at(42, S_RDY, 8'd1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    run_to(45);
    finish_phase();

    // Asynchronous reset mid-RUN.
    rst = 1'b1;
    #1;
    check("arst_rdy", {7'b0, ready}, 8'h00);
    check("arst_ch", {5'b0, ch_rst}, 8'h07);
    check("arst_pll", {7'b0, pll_rst}, 8'h01);

    // Saturation of a 2-bit retry counter over five timeouts.
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    cyc  = 0;
    expect_at(36, S_RETRY2, 8'd1);
    expect_at(72, S_RETRY2, 8'd2);
    expect_at(108, S_RETRY2, 8'd3);
    expect_at(144, S_RETRY2, 8'd3);
    expect_at(181, S_RETRY2, 8'd3);
    run_to(182);
    finish_phase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
